// File: rtl/tablet_panel_pkg.sv
// Shared types, cursor encodings and BCD helpers for the tablet-filler front panel.
package tablet_panel_pkg;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [2:0] bcd3_t;  // [2]=hundreds, [1]=tens, [0]=units

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EDIT,
    ST_COMMIT
  } state_t;

  localparam logic [2:0] POS_TAB_H = 3'd1;
  localparam logic [2:0] POS_TAB_T = 3'd2;
  localparam logic [2:0] POS_TAB_U = 3'd3;
  localparam logic [2:0] POS_BOT_H = 3'd5;
  localparam logic [2:0] POS_BOT_T = 3'd6;
  localparam logic [2:0] POS_BOT_U = 3'd7;

  function automatic logic [31:0] bcd3_to_bin(input bcd3_t d);
    return 32'(d[2]) * 32'd100 + 32'(d[1]) * 32'd10 + 32'(d[0]);
  endfunction

  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t d);
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  // Cursor walks the bottle digits first, then the tablet digits, then wraps.
  function automatic logic [2:0] pos_next(input logic [2:0] p);
    logic [2:0] n;
    case (p)
      POS_BOT_H: n = POS_BOT_T;
      POS_BOT_T: n = POS_BOT_U;
      POS_BOT_U: n = POS_TAB_H;
      POS_TAB_H: n = POS_TAB_T;
      POS_TAB_T: n = POS_TAB_U;
      default:   n = POS_BOT_H;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer: synchronises the raw level and emits a one-cycle pulse on an accepted press.
module key_debounce #(
  parameter int CNT_MAX = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  logic          sync0_q;
  logic          sync1_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= raw;
      sync1_q <= sync0_q;
      press_q <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (sync1_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= sync1_q;
        press_q <= sync1_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/tablet_set_input.sv
// Front-panel set-mode editor: debounced buttons drive a 6-digit BCD editor whose
// committed values are published in binary to the filling controller.
module tablet_set_input
  import tablet_panel_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int DEF_BOTTLE  = 100,
  parameter int DEF_TABLET  = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        running,
  output logic        set_mod,
  output logic [2:0]  pos,
  output logic [31:0] disp_bottle,
  output logic [31:0] disp_tablet,
  output logic [31:0] bottle_target,
  output logic [31:0] tablet_target,
  output logic        cfg_valid
);

  localparam int DB_RAW = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int DB_CNT = (DB_RAW < 1) ? 1 : DB_RAW;

  localparam bcd3_t DEF_BOT_DIG = {bcd_t'((DEF_BOTTLE / 100) % 10),
                                   bcd_t'((DEF_BOTTLE / 10) % 10),
                                   bcd_t'(DEF_BOTTLE % 10)};
  localparam bcd3_t DEF_TAB_DIG = {bcd_t'((DEF_TABLET / 100) % 10),
                                   bcd_t'((DEF_TABLET / 10) % 10),
                                   bcd_t'(DEF_TABLET % 10)};

  logic mode_p, next_p, inc_p, dec_p;

  key_debounce #(.CNT_MAX(DB_CNT)) u_db_mode (.clk(clk), .rst(rst), .raw(btn_mode), .press(mode_p));
  key_debounce #(.CNT_MAX(DB_CNT)) u_db_next (.clk(clk), .rst(rst), .raw(btn_next), .press(next_p));
  key_debounce #(.CNT_MAX(DB_CNT)) u_db_inc  (.clk(clk), .rst(rst), .raw(btn_inc),  .press(inc_p));
  key_debounce #(.CNT_MAX(DB_CNT)) u_db_dec  (.clk(clk), .rst(rst), .raw(btn_dec),  .press(dec_p));

  state_t      state_q;
  logic        set_mod_q;
  logic [2:0]  pos_q;
  logic        commit_q;
  bcd3_t       bot_w_q, tab_w_q;
  bcd3_t       bot_c_q, tab_c_q;
  bcd3_t       tab_fix_d;
  logic [1:0]  didx;

  // pos 1/5 -> hundreds (2), 2/6 -> tens (1), 3/7 -> units (0)
  assign didx = 2'd3 - pos_q[1:0];

  // A zero tablet count would fill empty bottles, so it commits as 001.
  always_comb begin
    tab_fix_d = tab_w_q;
    if (tab_w_q == '0) tab_fix_d[0] = 4'd1;
  end

  // ---- editor stage: FSM, working and committed digits ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      set_mod_q <= 1'b0;
      pos_q     <= POS_BOT_H;
      commit_q  <= 1'b0;
      bot_w_q   <= DEF_BOT_DIG;
      tab_w_q   <= DEF_TAB_DIG;
      bot_c_q   <= DEF_BOT_DIG;
      tab_c_q   <= DEF_TAB_DIG;
    end else begin
      commit_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mode_p && !running) begin
            bot_w_q   <= bot_c_q;
            tab_w_q   <= tab_c_q;
            pos_q     <= POS_BOT_H;
            set_mod_q <= 1'b1;
            state_q   <= ST_EDIT;
          end
        end
        ST_EDIT: begin
          if (mode_p) begin
            state_q <= ST_COMMIT;
          end else if (next_p) begin
            pos_q <= pos_next(pos_q);
          end else if (inc_p) begin
            if (pos_q[2]) bot_w_q[didx] <= bcd_inc(bot_w_q[didx]);
            else          tab_w_q[didx] <= bcd_inc(tab_w_q[didx]);
          end else if (dec_p) begin
            if (pos_q[2]) bot_w_q[didx] <= bcd_dec(bot_w_q[didx]);
            else          tab_w_q[didx] <= bcd_dec(tab_w_q[didx]);
          end
        end
        ST_COMMIT: begin
          tab_w_q   <= tab_fix_d;
          bot_c_q   <= bot_w_q;
          tab_c_q   <= tab_fix_d;
          commit_q  <= 1'b1;
          set_mod_q <= 1'b0;
          pos_q     <= POS_BOT_H;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [31:0] bot_tgt_q, tab_tgt_q, disp_bot_q, disp_tab_q;
  logic        cfg_valid_q;

  // ---- conversion stage: registered BCD->binary, cfg_valid tracks target update ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bot_tgt_q   <= 32'(DEF_BOTTLE);
      tab_tgt_q   <= 32'(DEF_TABLET);
      disp_bot_q  <= 32'(DEF_BOTTLE);
      disp_tab_q  <= 32'(DEF_TABLET);
      cfg_valid_q <= 1'b0;
    end else begin
      bot_tgt_q   <= bcd3_to_bin(bot_c_q);
      tab_tgt_q   <= bcd3_to_bin(tab_c_q);
      disp_bot_q  <= bcd3_to_bin(set_mod_q ? bot_w_q : bot_c_q);
      disp_tab_q  <= bcd3_to_bin(set_mod_q ? tab_w_q : tab_c_q);
      cfg_valid_q <= commit_q;
    end
  end

  assign set_mod       = set_mod_q;
  assign pos           = pos_q;
  assign disp_bottle   = disp_bot_q;
  assign disp_tablet   = disp_tab_q;
  assign bottle_target = bot_tgt_q;
  assign tablet_target = tab_tgt_q;
  assign cfg_valid     = cfg_valid_q;

endmodule
